// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce and key classification.
// Optional KEYPAD_COL_SYNC_EN inserts a two-flop synchronizer on the column inputs.
module keypad_scanner #(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] row,
  input  logic [3:0] col,
  output logic [3:0] key_value,
  output logic       key_pressed,
  output logic [2:0] is_sign_key,
  output logic       key_strobe
);

  localparam int MAX_CYC = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_RELEASE} state_t;

  state_t        r_state;
  logic [1:0]    r_k;
  logic [3:0]    r_row;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_col_lat;
  logic [3:0]    r_key_value;
  logic [2:0]    r_sign;
  logic          r_pressed;
  logic          r_strobe;

  logic [3:0]    w_col;
  logic          w_single;
  logic [1:0]    w_col_idx;
  logic [3:0]    w_code;
  logic [3:0]    w_row_next;

`ifdef KEYPAD_COL_SYNC_EN
  logic [3:0] r_col_s1;
  logic [3:0] r_col_s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col_s1 <= 4'hF;
      r_col_s2 <= 4'hF;
    end else begin
      r_col_s1 <= col;
      r_col_s2 <= r_col_s1;
    end
  end

  assign w_col = r_col_s2;
`else
  assign w_col = col;
`endif

  function automatic logic [3:0] f_key_code(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: f_key_code = 4'h1;
      4'h1: f_key_code = 4'h2;
      4'h2: f_key_code = 4'h3;
      4'h3: f_key_code = 4'hA;
      4'h4: f_key_code = 4'h4;
      4'h5: f_key_code = 4'h5;
      4'h6: f_key_code = 4'h6;
      4'h7: f_key_code = 4'hB;
      4'h8: f_key_code = 4'h7;
      4'h9: f_key_code = 4'h8;
      4'hA: f_key_code = 4'h9;
      4'hB: f_key_code = 4'hC;
      4'hC: f_key_code = 4'hE;
      4'hD: f_key_code = 4'h0;
      4'hE: f_key_code = 4'hF;
      default: f_key_code = 4'hD;
    endcase
  endfunction

  function automatic logic [2:0] f_sign(input logic [3:0] code);
    case (code)
      4'hE:    f_sign = 3'b001;
      4'hA:    f_sign = 3'b010;
      4'hB:    f_sign = 3'b100;
      4'hF:    f_sign = 3'b111;
      4'hC:    f_sign = 3'b011;
      4'hD:    f_sign = 3'b101;
      default: f_sign = 3'b000;
    endcase
  endfunction

  // Exactly one column low means a single unambiguous key in the driven row.
  assign w_single = (w_col == 4'b1110) || (w_col == 4'b1101) ||
                    (w_col == 4'b1011) || (w_col == 4'b0111);

  always_comb begin
    case (r_col_lat)
      4'b1101: w_col_idx = 2'd1;
      4'b1011: w_col_idx = 2'd2;
      4'b0111: w_col_idx = 2'd3;
      default: w_col_idx = 2'd0;
    endcase
  end

  assign w_code     = f_key_code(r_k, w_col_idx);
  assign w_row_next = {r_row[2:0], r_row[3]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= SCAN;
      r_k         <= 2'd0;
      r_row       <= 4'b1110;
      r_cnt       <= '0;
      r_col_lat   <= 4'hF;
      r_key_value <= 4'h0;
      r_sign      <= 3'b000;
      r_pressed   <= 1'b0;
      r_strobe    <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      case (r_state)
        SCAN: begin
          if (r_cnt == SCAN_LAST) begin
            r_cnt <= '0;
            if (w_single) begin
              r_col_lat <= w_col;
              r_state   <= DEB_PRESS;
            end else begin
              r_k   <= r_k + 2'd1;
              r_row <= w_row_next;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DEB_PRESS: begin
          if (w_col != r_col_lat) begin
            r_cnt   <= '0;
            r_k     <= r_k + 2'd1;
            r_row   <= w_row_next;
            r_state <= SCAN;
          end else if (r_cnt == DEB_LAST) begin
            r_cnt       <= '0;
            r_key_value <= w_code;
            r_sign      <= f_sign(w_code);
            r_pressed   <= 1'b1;
            r_strobe    <= 1'b1;
            r_state     <= HELD;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        HELD: begin
          // The first all-high cycle already counts toward the release debounce.
          if (w_col == 4'hF) begin
            r_cnt   <= CW'(1);
            r_state <= DEB_RELEASE;
          end
        end
        DEB_RELEASE: begin
          if (w_col != 4'hF) begin
            r_cnt <= '0;
          end else if (r_cnt == DEB_LAST) begin
            r_cnt     <= '0;
            r_pressed <= 1'b0;
            r_k       <= r_k + 2'd1;
            r_row     <= w_row_next;
            r_state   <= SCAN;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= SCAN;
      endcase
    end
  end

  assign row         = r_row;
  assign key_value   = r_key_value;
  assign is_sign_key = r_sign;
  assign key_pressed = r_pressed;
  assign key_strobe  = r_strobe;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a matrix model closes switches onto the driven rows.
module tb_keypad_scanner;
  localparam int SC = 4;
  localparam int DB = 8;
`ifdef KEYPAD_COL_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_value;
  logic        key_pressed;
  logic [2:0]  is_sign_key;
  logic        key_strobe;
  logic [15:0] keys = '0;

  int   checks = 0;
  int   errors = 0;
  int   strobe_cnt = 0;
  logic prev_strobe = 1'b0;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col), .key_value(key_value),
    .key_pressed(key_pressed), .is_sign_key(is_sign_key), .key_strobe(key_strobe)
  );

  // Switch matrix: a closed key at (r,c) pulls column c low while row r is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
  end

  always @(posedge clk) begin
    if (key_strobe) begin
      checks++;
      assert (prev_strobe === 1'b0) else begin
        errors++;
        $error("FAIL strobe_width observed=two consecutive high cycles expected=single-cycle pulse");
      end
      strobe_cnt <= strobe_cnt + 1;
    end
    prev_strobe <= key_strobe;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_strobe(input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (key_strobe) begin
        cyc = i;
        break;
      end
    end
    checks++;
    assert (cyc > 0) else begin
      errors++;
      $error("FAIL strobe_timeout observed=no strobe expected=strobe within %0d cycles", budget);
    end
  endtask

  initial begin
    int cyc;
    int base;
    int n;
    logic [3:0] prev_row;
    int         idx_t [4];
    logic [3:0] code_t[4];
    logic [2:0] sign_t[4];
    logic [3:0] rot_t [4];
    idx_t  = '{3, 11, 15, 13};
    code_t = '{4'hA, 4'hC, 4'hD, 4'h0};
    sign_t = '{3'b010, 3'b011, 3'b101, 3'b000};
    rot_t  = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

    // Reset state, with '7' already held
    keys = 16'h0100;
    repeat (3) @(negedge clk);
    check("rst_row", row, 4'b1110);
    check("rst_key_value", key_value, 4'h0);
    check("rst_sign", is_sign_key, 3'b000);
    check("rst_pressed", key_pressed, 1'b0);
    check("rst_strobe", key_strobe, 1'b0);

    // '7' held 40 cycles
    rst = 1'b1;
    wait_strobe(100, cyc);
`ifndef KEYPAD_COL_SYNC_EN
    check("seven_latency", cyc, 20);
`endif
    check("seven_value", key_value, 4'h7);
    check("seven_sign", is_sign_key, 3'b000);
    check("seven_pressed", key_pressed, 1'b1);
    @(negedge clk);
    check("seven_strobe_low", key_strobe, 1'b0);
    repeat (38) @(negedge clk);
    check("seven_held", key_pressed, 1'b1);
    check("seven_row_frozen", row, 4'b1011);
    check("seven_one_strobe", strobe_cnt, 1);
    keys = '0;
    repeat (7 + L) @(negedge clk);
    check("seven_release_early", key_pressed, 1'b1);
    @(negedge clk);
    check("seven_release", key_pressed, 1'b0);
    check("seven_value_kept", key_value, 4'h7);
    repeat (20) @(negedge clk);

    // '*' then '#'
    keys = 16'h1000;
    wait_strobe(100, cyc);
    check("star_value", key_value, 4'hE);
    check("star_sign", is_sign_key, 3'b001);
    keys = '0;
    repeat (20) @(negedge clk);
    keys = 16'h4000;
    wait_strobe(100, cyc);
    check("hash_value", key_value, 4'hF);
    check("hash_sign", is_sign_key, 3'b111);
    keys = '0;
    repeat (20) @(negedge clk);
    check("star_hash_strobes", strobe_cnt, 3);

    // '5' bouncing, then stable
    base = strobe_cnt;
    for (int b = 0; b < 5; b++) begin
      keys = 16'h0020;
      repeat (3) @(negedge clk);
      keys = '0;
      @(negedge clk);
    end
    check("bounce_no_strobe", strobe_cnt, base);
    check("bounce_value_kept", key_value, 4'hF);
    keys = 16'h0020;
    wait_strobe(100, cyc);
    check("five_value", key_value, 4'h5);
    check("five_sign", is_sign_key, 3'b000);
    @(negedge clk);
    keys = '0;
    repeat (20) @(negedge clk);
    check("five_one_strobe", strobe_cnt, base + 1);

    // Remaining sign keys and digit 0
    for (int t = 0; t < 4; t++) begin
      keys = 16'h0001 << idx_t[t];
      wait_strobe(100, cyc);
      check("table_value", key_value, code_t[t]);
      check("table_sign", is_sign_key, sign_t[t]);
      keys = '0;
      repeat (20) @(negedge clk);
    end

    // '1' and '2' together: ambiguous, keep scanning
    base = strobe_cnt;
    keys = 16'h0003;
    n = 0;
    while (row !== 4'b1110 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("dual_row_start", row, 4'b1110);
    for (int j = 0; j < 4; j++) begin
      prev_row = row;
      n = 0;
      while (row === prev_row && n < 10) begin
        @(negedge clk);
        n++;
      end
      check("dual_row_seq", row, rot_t[j]);
      if (j > 0) check("dual_row_dwell", n, SC);
    end
    check("dual_no_strobe", strobe_cnt, base);
    check("dual_not_pressed", key_pressed, 1'b0);
    keys = '0;
    repeat (5) @(negedge clk);

    // 'B' held through a reset pulse
    keys = 16'h0080;
    wait_strobe(100, cyc);
    check("b_value", key_value, 4'hB);
    repeat (5) @(negedge clk);
    check("b_held", key_pressed, 1'b1);
    rst = 1'b0;
    #1;
    check("async_rst_value", key_value, 4'h0);
    check("async_rst_sign", is_sign_key, 3'b000);
    check("async_rst_pressed", key_pressed, 1'b0);
    check("async_rst_row", row, 4'b1110);
    repeat (3) @(negedge clk);
    base = strobe_cnt;
    rst = 1'b1;
    wait_strobe(100, cyc);
`ifndef KEYPAD_COL_SYNC_EN
    check("b_redebounce_latency", cyc, 16);
`endif
    check("b_value_after_rst", key_value, 4'hB);
    check("b_sign_after_rst", is_sign_key, 3'b100);
    check("b_pressed_after_rst", key_pressed, 1'b1);
    keys = '0;
    repeat (20) @(negedge clk);
    check("b_one_strobe", strobe_cnt, base + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
